// File: rtl/snoop_arbiter_if.sv
// rtl/snoop_arbiter_if.sv - requester command ports and CPU snoop bus for snoop_arbiter
//
// Purpose: bundles both requester handshakes and the snoop port so the
// arbiter and its environment share one definition of widths and directions.
//
// Signals:
//   rN_req/rN_op/rN_d   requester N command (level request, op code, address/data)
//   rN_ack/rN_q         one-cycle completion pulse and read data for requester N
//   snoopa/snoopd       snoop address and write data
//   snoopq              snoop read data
//   snoopp/snoopm       program / data memory write strobes
//   busy/grant          arbiter activity and index of the requester being served
//
// Modports: slave = arbiter side, master = requester/memory side.

interface snoop_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              r0_req;
  logic [1:0]        r0_op;
  logic [DATA_W-1:0] r0_d;
  logic              r0_ack;
  logic [DATA_W-1:0] r0_q;

  logic              r1_req;
  logic [1:0]        r1_op;
  logic [DATA_W-1:0] r1_d;
  logic              r1_ack;
  logic [DATA_W-1:0] r1_q;

  logic [ADDR_W-1:0] snoopa;
  logic [DATA_W-1:0] snoopd;
  logic [DATA_W-1:0] snoopq;
  logic              snoopp;
  logic              snoopm;
  logic              busy;
  logic              grant;

  modport slave (
    input  r0_req, r0_op, r0_d, r1_req, r1_op, r1_d, snoopq,
    output r0_ack, r0_q, r1_ack, r1_q, snoopa, snoopd, snoopp, snoopm, busy, grant
  );

  modport master (
    output r0_req, r0_op, r0_d, r1_req, r1_op, r1_d, snoopq,
    input  r0_ack, r0_q, r1_ack, r1_q, snoopa, snoopd, snoopp, snoopm, busy, grant
  );
endinterface

// File: rtl/snoop_arbiter.sv
// rtl/snoop_arbiter.sv - shares the CPU snoop port between the SPI and boot-loader requesters
//
// Purpose: accepts commands from two requesters, each with a private
// auto-incrementing address register, and sequences every access onto the
// snoop port: address setup, a one-cycle write strobe or a read-latency wait,
// then a one-cycle ack to the served requester.
//
// Ports:
//   clk    snoop clock (clk_main domain), all logic on posedge
//   reset  synchronous, active-low
//   bus    snoop_arbiter_if.slave: r0_*/r1_* command handshakes, snoop bus,
//          busy and grant status
//
// Parameters: ADDR_W (address width, wraps modulo 2^ADDR_W), DATA_W (data
// width), READ_LAT (1..15 clocks from snoopa stable to snoopq valid).
//
// Build option: define SNOOP_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins a tie); default is round-robin.

module snoop_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  snoop_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, DONE} state_t;

  localparam logic [1:0]        OP_SETA = 2'b00;
  localparam logic [1:0]        OP_PROG = 2'b01;
  localparam logic [1:0]        OP_READ = 2'b10;
  localparam logic [1:0]        OP_MEMW = 2'b11;
  localparam logic [3:0]        LAT     = 4'(READ_LAT);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t            state, state_nxt;
  logic              grant_r;
  logic [1:0]        op_r;
  logic [DATA_W-1:0] d_r;
  logic [ADDR_W-1:0] addr_r [2];
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] snoopa_r;
  logic [DATA_W-1:0] snoopd_r;
  logic              snoopp_r, snoopm_r;
  logic [DATA_W-1:0] q0_r, q1_r;

  logic              any_req;
  logic              winner;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_d;

  assign any_req = bus.r0_req | bus.r1_req;

`ifdef SNOOP_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it asks; requester 1 may starve.
  assign winner = !bus.r0_req;
`else
  // last_r starts at 1 so requester 0 wins the first tie after reset.
  logic last_r;
  assign winner = (bus.r0_req && bus.r1_req) ? !last_r : bus.r1_req;
`endif

  assign sel_op = winner ? bus.r1_op : bus.r0_op;
  assign sel_d  = winner ? bus.r1_d  : bus.r0_d;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP: begin
        case (op_r)
          OP_SETA: state_nxt = DONE;
          OP_READ: state_nxt = WAIT;
          default: state_nxt = STROBE;
        endcase
      end
      STROBE:  state_nxt = DONE;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_r   <= 1'b0;
      op_r      <= OP_SETA;
      d_r       <= '0;
      addr_r[0] <= '0;
      addr_r[1] <= '0;
      cnt       <= '0;
      snoopa_r  <= '0;
      snoopd_r  <= '0;
      snoopp_r  <= 1'b0;
      snoopm_r  <= 1'b0;
      q0_r      <= '0;
      q1_r      <= '0;
`ifndef SNOOP_ARB_FIXED_PRIO_EN
      last_r    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Only the accepting edge samples op/d; snoopa/snoopd otherwise hold.
          if (any_req) begin
            grant_r  <= winner;
            op_r     <= sel_op;
            d_r      <= sel_d;
            snoopa_r <= addr_r[winner];
            snoopd_r <= sel_d;
          end
        end
        SETUP: begin
          case (op_r)
            OP_SETA: addr_r[grant_r] <= ADDR_W'(d_r);
            OP_PROG: snoopp_r <= 1'b1;
            OP_MEMW: snoopm_r <= 1'b1;
            default: cnt <= LAT;
          endcase
        end
        STROBE: begin
          snoopp_r        <= 1'b0;
          snoopm_r        <= 1'b0;
          addr_r[grant_r] <= addr_r[grant_r] + ONE_A;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt counts down from READ_LAT, so this is the last WAIT cycle.
          if (cnt == 4'd1) begin
            if (grant_r) q1_r <= bus.snoopq;
            else         q0_r <= bus.snoopq;
            addr_r[grant_r] <= addr_r[grant_r] + ONE_A;
          end
        end
        DONE: begin
`ifndef SNOOP_ARB_FIXED_PRIO_EN
          last_r <= grant_r;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.r0_ack = (state == DONE) && !grant_r;
  assign bus.r1_ack = (state == DONE) &&  grant_r;
  assign bus.r0_q   = q0_r;
  assign bus.r1_q   = q1_r;
  assign bus.snoopa = snoopa_r;
  assign bus.snoopd = snoopd_r;
  assign bus.snoopp = snoopp_r;
  assign bus.snoopm = snoopm_r;
  assign bus.busy   = (state != IDLE);
  assign bus.grant  = grant_r;

endmodule

// File: tb/tb_snoop_arbiter.sv
// tb/tb_snoop_arbiter.sv - scoreboard bench for snoop_arbiter

module tb_snoop_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  parameter int READ_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  snoop_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  snoop_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Snoop memory: read data is a fixed scramble of the address.
  function automatic logic [7:0] rom(input logic [7:0] a);
    logic [7:0] m;
    m = a * 8'd37;
    return m ^ 8'hC5 ^ {a[2:0], a[7:3]};
  endfunction

  assign bus.snoopq = rom(bus.snoopa);

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] addr;
  } cmd_t;

  cmd_t       q0[$];
  cmd_t       q1[$];
  logic [7:0] addr_m [2];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         gseq[$];
  int         ack0_t[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic req, input logic [1:0] op, input logic [7:0] d);
    if (r == 0) begin
      bus.r0_req = req; bus.r0_op = op; bus.r0_d = d;
    end else begin
      bus.r1_req = req; bus.r1_op = op; bus.r1_d = d;
    end
  endtask

  // Reference model: private per-requester address, set or +1 mod 256.
  task automatic push_cmd(input int r, input logic [1:0] op, input logic [7:0] d);
    cmd_t c;
    c.op = op; c.d = d; c.addr = addr_m[r];
    if (r == 0) q0.push_back(c); else q1.push_back(c);
    addr_m[r] = (op == 2'b00) ? d : addr_m[r] + 8'd1;
  endtask

  // Entered and left 1 time unit after a posedge.
  task automatic do_cmd(input int r, input logic [1:0] op, input logic [7:0] d,
                        input bit keep, input bit drop_early);
    bit got;
    push_cmd(r, op, d);
    drive(r, 1'b1, op, d);
    if (drop_early) begin
      @(posedge clk); #1;
      drive(r, 1'b0, op, d);
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((r == 0) ? bus.r0_ack : bus.r1_ack) got = 1'b1;
    end
    check($sformatf("ack_seen_r%0d", r), 32'(got), 32'd1);
    @(posedge clk); #1;
    if (!keep) drive(r, 1'b0, op, d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.r0_ack, bus.r1_ack, bus.snoopp, bus.snoopm, bus.busy, bus.grant}), 32'd0);
    check({tag, "_q"}, 32'({bus.r0_q, bus.r1_q}), 32'd0);
    check({tag, "_snoop"}, 32'({bus.snoopa, bus.snoopd}), 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(0, 1'b0, 2'b00, 8'h00);
    drive(1, 1'b0, 2'b00, 8'h00);
    q0.delete(); q1.delete();
    addr_m[0] = 8'h00; addr_m[1] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic rand_drv(input int r, input int n);
    bit k;
    for (int i = 0; i < n; i++) begin
      k = (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      do_cmd(r, 2'($urandom_range(0, 3)), 8'($urandom), k, 1'b0);
      if (!k) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  // Monitor: arbitration rule, strobe shape, latency and read data.
  bit         prev_busy, prev_r0, prev_r1, active, last_m, s_p, s_m;
  int         t_acc, g_w, s_cnt, r_a, lat;
  logic [7:0] s_a, s_d;
  cmd_t       c_m;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      prev_busy = 0; prev_r0 = 0; prev_r1 = 0; active = 0; last_m = 1;
    end else begin
      if (bus.busy && !prev_busy) begin
`ifdef SNOOP_ARB_FIXED_PRIO_EN
        g_w = prev_r0 ? 0 : 1;
`else
        g_w = (prev_r0 && prev_r1) ? int'(!last_m) : (prev_r1 ? 1 : 0);
`endif
        check("grant", 32'(bus.grant), 32'(g_w));
        gseq.push_back(int'(bus.grant));
        active = 1; t_acc = cyc; s_cnt = 0; s_p = 0; s_m = 0;
        s_a = bus.snoopa; s_d = bus.snoopd;
        check("queue_depth_setup", 32'((g_w == 0) ? q0.size() : q1.size()), 32'd1);
        if (((g_w == 0) ? q0.size() : q1.size()) > 0) begin
          c_m = (g_w == 0) ? q0[0] : q1[0];
          check("setup_addr", 32'(bus.snoopa), 32'(c_m.addr));
          check("setup_data", 32'(bus.snoopd), 32'(c_m.d));
        end
      end
      if (bus.snoopp || bus.snoopm) begin
        s_cnt++;
        s_p |= bus.snoopp;
        s_m |= bus.snoopm;
        check("strobe_excl", 32'(bus.snoopp & bus.snoopm), 32'd0);
        check("strobe_stable", 32'({bus.snoopa, bus.snoopd}), 32'({s_a, s_d}));
      end
      if (bus.r0_ack || bus.r1_ack) begin
        r_a = bus.r1_ack ? 1 : 0;
        check("ack_single", 32'(bus.r0_ack & bus.r1_ack), 32'd0);
        check("ack_active", 32'(active), 32'd1);
        check("ack_owner", 32'(r_a), 32'(g_w));
        check("queue_depth_ack", 32'((r_a == 0) ? q0.size() : q1.size()), 32'd1);
        if (((r_a == 0) ? q0.size() : q1.size()) > 0) begin
          c_m = (r_a == 0) ? q0.pop_front() : q1.pop_front();
          lat = (c_m.op == 2'b00) ? 2 : (c_m.op == 2'b10) ? 2 + READ_LAT : 3;
          check("latency", 32'(cyc - t_acc + 1), 32'(lat));
          check("strobe_count", 32'(s_cnt), (c_m.op[0]) ? 32'd1 : 32'd0);
          check("strobe_kind", 32'({s_p, s_m}), 32'({c_m.op == 2'b01, c_m.op == 2'b11}));
          if (c_m.op == 2'b10)
            check("read_q", 32'(r_a ? bus.r1_q : bus.r0_q), 32'(rom(c_m.addr)));
        end
        if (r_a == 0) ack0_t.push_back(cyc);
        last_m = r_a[0];
        active = 0;
      end
      prev_busy = bus.busy; prev_r0 = bus.r0_req; prev_r1 = bus.r1_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    apply_reset();

    // Set address then read it back.
    do_cmd(0, 2'b00, 8'h3C, 1'b0, 1'b0);
    do_cmd(0, 2'b10, 8'h00, 1'b0, 1'b0);
    check("t1_r0_q", 32'(bus.r0_q), 32'(rom(8'h3C)));

    // Data write at 0xFF, then program write wraps to 0x00.
    do_cmd(1, 2'b00, 8'hFF, 1'b0, 1'b0);
    do_cmd(1, 2'b11, 8'hA5, 1'b0, 1'b0);
    do_cmd(1, 2'b01, 8'h5A, 1'b0, 1'b0);
    do_cmd(1, 2'b10, 8'h00, 1'b0, 1'b0);
    check("t2_r1_q", 32'(bus.r1_q), 32'(rom(8'h01)));

    // Requester drops req right after acceptance.
    do_cmd(0, 2'b01, 8'h77, 1'b0, 1'b1);
    do_cmd(0, 2'b10, 8'h00, 1'b0, 1'b0);
    check("t4_r0_q", 32'(bus.r0_q), 32'(rom(8'h3E)));

    // Both requesters contend continuously from reset.
    apply_reset();
    gseq.delete();
    fork
      for (int i = 0; i < 4; i++) do_cmd(0, 2'($urandom_range(0, 3)), 8'($urandom), i < 3, 1'b0);
      for (int j = 0; j < 4; j++) do_cmd(1, 2'($urandom_range(0, 3)), 8'($urandom), j < 3, 1'b0);
    join
    check("t3_grant_count", 32'(gseq.size()), 32'd8);
    for (int i = 0; i < 8 && i < gseq.size(); i++) begin
`ifdef SNOOP_ARB_FIXED_PRIO_EN
      check($sformatf("t3_grant_%0d", i), 32'(gseq[i]), (i < 4) ? 32'd0 : 32'd1);
`else
      check($sformatf("t3_grant_%0d", i), 32'(gseq[i]), 32'(i % 2));
`endif
    end

    // Reset in the middle of an r1 read.
    do_cmd(1, 2'b00, 8'h44, 1'b0, 1'b0);
    push_cmd(1, 2'b10, 8'h00);
    drive(1, 1'b1, 2'b10, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    apply_reset();
    do_cmd(1, 2'b10, 8'h00, 1'b0, 1'b0);
    check("t5_r1_q_addr0", 32'(bus.r1_q), 32'(rom(8'h00)));

    // Back-to-back reads of 0x10..0x13.
    do_cmd(0, 2'b00, 8'h10, 1'b0, 1'b0);
    ack0_t.delete();
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, 2'b10, 8'h00, i < 3, 1'b0);
      check($sformatf("t6_q_%0d", i), 32'(bus.r0_q), 32'(rom(8'h10 + 8'(i))));
    end
    check("t6_ack_count", 32'(ack0_t.size()), 32'd4);
    for (int i = 1; i < 4 && i < ack0_t.size(); i++)
      check($sformatf("t6_spacing_%0d", i), 32'(ack0_t[i] - ack0_t[i-1]), 32'(3 + READ_LAT));

    // Randomized traffic from both requesters.
    fork
      rand_drv(0, 12);
      rand_drv(1, 12);
    join

    repeat (5) @(posedge clk);
    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
